// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry elastic buffer for ALU results, the
// architectural Z/V/C flags register, and a forwarding bus for operand bypass.
module alu_result_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_carry,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_setflags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_c,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_result,
  output logic [1:0]        occupancy
);

  localparam int unsigned DEPTH = 2;

  logic [DATA_W-1:0] result_q [DEPTH];
  logic [DATA_W-1:0] result_d [DEPTH];
  logic [REG_AW-1:0] rd_q     [DEPTH];
  logic [REG_AW-1:0] rd_d     [DEPTH];
  logic              we_q     [DEPTH];
  logic              we_d     [DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_v_q, flag_v_d;
  logic              flag_c_q, flag_c_d;

  logic fire_in;
  logic fire_out;
  logic young_idx;

  // Handshakes depend on registered occupancy only
  always_comb begin
    in_ready  = (count_q != 2'd2) & ~Reset;
    out_valid = (count_q != 2'd0);
    fire_in   = in_valid & in_ready;
    fire_out  = out_valid & out_ready;
  end

  // Next-state: FIFO write/read, occupancy and flags update
  always_comb begin
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    flag_c_d = flag_c_q;

    if (fire_in) begin
      result_d[wr_ptr_q] = in_result;
      rd_d[wr_ptr_q]     = in_rd;
      // R0 is hardwired zero, so a write to it is dropped here
      we_d[wr_ptr_q]     = in_regwrite & (in_rd != '0);
      wr_ptr_d           = ~wr_ptr_q;
      if (in_setflags) begin
        flag_z_d = in_zero;
        flag_v_d = in_overflow;
        flag_c_d = in_carry;
      end
    end

    if (fire_out) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({fire_in, fire_out})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset that discards pending entries
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        rd_q[i]     <= '0;
        we_q[i]     <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Head entry drives writeback; zeroed when empty so stale data never shows
  always_comb begin
    out_result   = out_valid ? result_q[rd_ptr_q] : '0;
    out_rd       = out_valid ? rd_q[rd_ptr_q]     : '0;
    out_regwrite = out_valid & we_q[rd_ptr_q];
    occupancy    = count_q;
    flag_z       = flag_z_q;
    flag_v       = flag_v_q;
    flag_c       = flag_c_q;
  end

  // Forwarding picks the youngest pending register write (slot behind wr_ptr)
  always_comb begin
    young_idx  = ~wr_ptr_q;
    fwd_valid  = 1'b0;
    fwd_rd     = '0;
    fwd_result = '0;
    if ((count_q != 2'd0) && we_q[young_idx]) begin
      fwd_valid  = 1'b1;
      fwd_rd     = rd_q[young_idx];
      fwd_result = result_q[young_idx];
    end else if ((count_q == 2'd2) && we_q[rd_ptr_q]) begin
      fwd_valid  = 1'b1;
      fwd_rd     = rd_q[rd_ptr_q];
      fwd_result = result_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus a queue scoreboard
// that tracks every accepted entry and compares it at writeback.
module tb_alu_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_zero;
  logic        in_overflow;
  logic        in_carry;
  logic [2:0]  in_rd;
  logic        in_regwrite;
  logic        in_setflags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_regwrite;
  logic        flag_z;
  logic        flag_v;
  logic        flag_c;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [15:0] fwd_result;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_result_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_carry     (in_carry),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .in_setflags  (in_setflags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_c       (flag_c),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_result   (fwd_result),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: sampled mid-cycle, predicts what the next rising edge transfers
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: out_valid=1 with result %h but nothing expected", out_result);
        end else begin
          e = q.pop_front();
          if ({out_result, out_rd, out_regwrite} !== {e.res, e.rd, e.we}) begin
            errors++;
            $display("FAIL sb_order: got res=%h rd=%0d we=%b expected res=%h rd=%0d we=%b",
                     out_result, out_rd, out_regwrite, e.res, e.rd, e.we);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_t n;
        n.res = in_result;
        n.rd  = in_rd;
        n.we  = in_regwrite & (in_rd != 3'd0);
        q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] d,
                       input logic w, input logic sf, input logic z,
                       input logic ov, input logic c);
    in_valid    = v;
    in_result   = r;
    in_rd       = d;
    in_regwrite = w;
    in_setflags = sf;
    in_zero     = z;
    in_overflow = ov;
    in_carry    = c;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({occupancy, out_valid, in_ready, flag_z, flag_v, flag_c, fwd_valid} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: occ=%0d ov=%b ir=%b z=%b v=%b c=%b fv=%b expected all 0",
               occupancy, out_valid, in_ready, flag_z, flag_v, flag_c, fwd_valid);
    end
    checks++;
    if ({out_result, out_rd, out_regwrite, fwd_rd, fwd_result} !== 39'b0) begin
      errors++;
      $display("FAIL reset_data: res=%h rd=%0d we=%b frd=%0d fres=%h expected 0",
               out_result, out_rd, out_regwrite, fwd_rd, fwd_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if ({out_valid, out_result, out_rd, out_regwrite, occupancy} !== {1'b1, 16'h1234, 3'd3, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL single_latency: ov=%b res=%h rd=%0d we=%b occ=%0d expected 1 1234 3 1 1",
               out_valid, out_result, out_rd, out_regwrite, occupancy);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: occ=%0d ov=%b expected 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_block: occ=%0d in_ready=%b expected 2 0", occupancy, in_ready);
    end
    drive(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (occupancy !== 2'd2 || out_result !== 16'h0001) begin
      errors++;
      $display("FAIL full_hold: occ=%0d head=%h expected 2 0001", occupancy, out_result);
    end
    out_ready = 1'b1;
    tick();
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (occupancy !== 2'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: occ=%0d pending=%0d expected 0 0", occupancy, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    out_ready = 1'b0;
    drive(1'b1, 16'h0FFF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 3'(i % 8), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (occupancy !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_occupancy: %0d cycles with occupancy != 1 expected 0", bad);
    end
    idle();
    tick();
    checks++;
    if (occupancy !== 2'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: occ=%0d pending=%0d expected 0 0", occupancy, q.size());
    end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if ({flag_z, flag_v, flag_c} !== 3'b100) begin
      errors++;
      $display("FAIL flags_set: zvc=%b%b%b expected 100", flag_z, flag_v, flag_c);
    end
    drive(1'b1, 16'h8000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({flag_z, flag_v, flag_c} !== 3'b100) begin
      errors++;
      $display("FAIL flags_nosetflags: zvc=%b%b%b expected 100", flag_z, flag_v, flag_c);
    end
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 16'h0022, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if ({flag_z, flag_v, flag_c} !== 3'b100) begin
      errors++;
      $display("FAIL flags_blocked: zvc=%b%b%b expected 100", flag_z, flag_v, flag_c);
    end
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_forwarding();
    out_ready = 1'b0;
    drive(1'b1, 16'h00AA, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({fwd_valid, fwd_rd, fwd_result} !== {1'b1, 3'd5, 16'h00AA}) begin
      errors++;
      $display("FAIL fwd_first: v=%b rd=%0d res=%h expected 1 5 00aa", fwd_valid, fwd_rd, fwd_result);
    end
    drive(1'b1, 16'h00BB, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({fwd_valid, fwd_rd, fwd_result} !== {1'b1, 3'd5, 16'h00BB}) begin
      errors++;
      $display("FAIL fwd_youngest: v=%b rd=%0d res=%h expected 1 5 00bb", fwd_valid, fwd_rd, fwd_result);
    end
    idle();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h00CC, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({fwd_valid, fwd_rd, fwd_result, occupancy} !== {1'b1, 3'd5, 16'h00BB, 2'd2}) begin
      errors++;
      $display("FAIL fwd_skip_r0: v=%b rd=%0d res=%h occ=%0d expected 1 5 00bb 2",
               fwd_valid, fwd_rd, fwd_result, occupancy);
    end
    idle();
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_result, out_rd, out_regwrite, fwd_valid, fwd_rd, fwd_result} !==
        {1'b1, 16'h00CC, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL r0_entry: ov=%b res=%h rd=%0d we=%b fv=%b frd=%0d fres=%h expected 1 00cc 0 0 0 0 0000",
               out_valid, out_result, out_rd, out_regwrite, fwd_valid, fwd_rd, fwd_result);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h6666, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (occupancy !== 2'd2 || {flag_z, flag_c} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: occ=%0d z=%b c=%b expected 2 1 1", occupancy, flag_z, flag_c);
    end
    idle();
    out_ready = 1'b1;
    rst = 1'b1;
    checks++;
    #1;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: in_ready=%b expected 0", in_ready);
    end
    tick();
    checks++;
    if ({occupancy, out_valid, flag_z, flag_v, flag_c, fwd_valid, out_result} !== 23'b0) begin
      errors++;
      $display("FAIL midflight_reset: occ=%0d ov=%b zvc=%b%b%b fv=%b res=%h expected all 0",
               occupancy, out_valid, flag_z, flag_v, flag_c, fwd_valid, out_result);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: in_ready=%b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_empty: ov=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flags();
    test_forwarding();
    test_reset_midflight();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
